// File: rtl/signed_down_syncreset_modulomax_counter_pkg.sv
// Shared definitions for the modulo-MAX down counter: FSM states, mode
// encodings and the parameter legality check used at elaboration.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_WRAP    = 1'b1;

  // True when a modulus of max fits in a counter of max_sqrt bits.
  function automatic bit max_fits(input longint max, input int max_sqrt);
    return max <= (longint'(1) << max_sqrt);
  endfunction

endpackage

// File: rtl/signed_down_syncreset_modulomax_counter_if.sv
// Control/status bundle of the down counter; the block owning the counter
// uses the slave view, whoever drives it uses the master view.
interface signed_down_syncreset_modulomax_counter_if #(
  parameter int MAX_SQRT = 4
);
  logic                CE;
  logic                L;
  logic [MAX_SQRT-1:0] D;
  logic                MODE;
  logic [MAX_SQRT-1:0] Q;
  logic                TC;
  logic                BUSY;

  modport master (output CE, L, D, MODE, input Q, TC, BUSY);
  modport slave  (input CE, L, D, MODE, output Q, TC, BUSY);
endinterface

// File: rtl/signed_down_syncreset_modulomax_counter_down_mod_step.sv
// Combinational next-value unit: one decrement step modulo MAX, with a flag
// marking the 1 -> 0 transition that produces the terminal count.
module down_mod_step
  import counter_pkg::*;
#(
  parameter int MAX_SQRT = 4,
  parameter int MAX      = MAX_SQRT * MAX_SQRT
) (
  input  logic [MAX_SQRT-1:0] q,
  input  logic                mode,
  output logic [MAX_SQRT-1:0] q_next,
  output logic                hit_zero
);

  localparam logic [MAX_SQRT-1:0] Q_TOP = MAX_SQRT'(MAX - 1);

  always_comb begin
    q_next   = q;
    hit_zero = 1'b0;
    if (q != '0) begin
      q_next   = q - MAX_SQRT'(1);
      hit_zero = (q == MAX_SQRT'(1));
    end else if (mode == MODE_WRAP) begin
      // Wrapping from 0 reloads the top value without a terminal count.
      q_next = Q_TOP;
    end
  end

endmodule

// File: rtl/signed_down_syncreset_modulomax_counter.sv
// Loadable modulo-MAX down counter with one-shot / auto-wrap modes, clock
// enable, registered terminal-count pulse and busy flag.
module signed_down_syncreset_modulomax_counter
  import counter_pkg::*;
#(
  parameter int MAX_SQRT = 4,
  parameter int MAX      = MAX_SQRT * MAX_SQRT
) (
  input  logic C,
  input  logic CLR,
  signed_down_syncreset_modulomax_counter_if.slave bus
);

  if (MAX_SQRT < 2 || MAX_SQRT == 3 || !max_fits(MAX, MAX_SQRT)) begin : g_param_err
    $error("illegal counter parameters: MAX_SQRT=%0d MAX=%0d", MAX_SQRT, MAX);
  end

  state_t              state;
  logic                mode_r;
  logic [MAX_SQRT-1:0] q_r;
  logic                tc_r;
  logic                busy_r;

  logic [MAX_SQRT-1:0] d_red;
  logic [MAX_SQRT-1:0] q_next;
  logic                hit_zero;

  // Reduction only changes D when D >= MAX, so a plain modulo is exact.
  assign d_red = MAX_SQRT'(32'(bus.D) % MAX);

  down_mod_step #(
    .MAX_SQRT (MAX_SQRT),
    .MAX      (MAX)
  ) u_step (
    .q        (q_r),
    .mode     (mode_r),
    .q_next   (q_next),
    .hit_zero (hit_zero)
  );

  always_ff @(posedge C) begin
    if (CLR) begin
      state  <= IDLE;
      mode_r <= MODE_ONESHOT;
      q_r    <= '0;
      tc_r   <= 1'b0;
      busy_r <= 1'b0;
    end else if (bus.L) begin
      q_r    <= d_red;
      mode_r <= bus.MODE;
      tc_r   <= 1'b0;
      if (bus.MODE == MODE_ONESHOT && d_red == '0) begin
        state  <= DONE;
        busy_r <= 1'b0;
      end else begin
        state  <= RUN;
        busy_r <= 1'b1;
      end
    end else begin
      // TC is a single-cycle pulse: it only survives the RUN/CE branch below.
      tc_r <= 1'b0;
      case (state)
        RUN: begin
          if (bus.CE) begin
            q_r  <= q_next;
            tc_r <= hit_zero;
            if (hit_zero && mode_r == MODE_ONESHOT) begin
              state  <= DONE;
              busy_r <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Q    = q_r;
  assign bus.TC   = tc_r;
  assign bus.BUSY = busy_r;

endmodule

// File: tb/tb_signed_down_syncreset_modulomax_counter.sv
// Directed bench for the modulo-16 down counter: reset, one-shot, wrap,
// enable gaps and load corner cases.
module tb_signed_down_syncreset_modulomax_counter;

  logic C;
  logic CLR;
  int   checks;
  int   errors;

  signed_down_syncreset_modulomax_counter_if #(.MAX_SQRT(4)) bus ();

  signed_down_syncreset_modulomax_counter #(
    .MAX_SQRT (4),
    .MAX      (16)
  ) dut (
    .C   (C),
    .CLR (CLR),
    .bus (bus)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    CLR = 1'b1; bus.L = 1'b0; bus.CE = 1'b0; bus.D = '0; bus.MODE = 1'b0;
    tick();
    exp = {4'd0, 1'b0, 1'b0};
    checks++;
    if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
      errors++;
      $display("FAIL reset_state: got {Q,TC,BUSY}=%b, expected %b", {bus.Q, bus.TC, bus.BUSY}, exp);
    end
    CLR = 1'b0; bus.CE = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
      errors++;
      $display("FAIL idle_ce_ignored: got {Q,TC,BUSY}=%b, expected %b", {bus.Q, bus.TC, bus.BUSY}, exp);
    end
    // Reset in the middle of a count.
    bus.CE = 1'b0; bus.L = 1'b1; bus.D = 4'd9; bus.MODE = 1'b0;
    tick();
    exp = {4'd9, 1'b0, 1'b1};
    checks++;
    if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
      errors++;
      $display("FAIL reset_midcount_load: got {Q,TC,BUSY}=%b, expected %b", {bus.Q, bus.TC, bus.BUSY}, exp);
    end
    bus.L = 1'b0; bus.CE = 1'b1;
    tick(); tick(); tick();
    exp = {4'd6, 1'b0, 1'b1};
    checks++;
    if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
      errors++;
      $display("FAIL reset_midcount_count: got {Q,TC,BUSY}=%b, expected %b", {bus.Q, bus.TC, bus.BUSY}, exp);
    end
    CLR = 1'b1;
    tick();
    exp = {4'd0, 1'b0, 1'b0};
    checks++;
    if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
      errors++;
      $display("FAIL reset_midcount_clr: got {Q,TC,BUSY}=%b, expected %b", {bus.Q, bus.TC, bus.BUSY}, exp);
    end
    CLR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
        errors++;
        $display("FAIL reset_after_ce%0d: got {Q,TC,BUSY}=%b, expected %b", i, {bus.Q, bus.TC, bus.BUSY}, exp);
      end
    end
    bus.CE = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [5:0] exp_tab [6];
    exp_tab = '{{4'd3, 1'b0, 1'b1}, {4'd2, 1'b0, 1'b1}, {4'd1, 1'b0, 1'b1},
                {4'd0, 1'b1, 1'b0}, {4'd0, 1'b0, 1'b0}, {4'd0, 1'b0, 1'b0}};
    bus.L = 1'b1; bus.D = 4'd3; bus.MODE = 1'b0; bus.CE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.L = 1'b0;
      checks++;
      if ({bus.Q, bus.TC, bus.BUSY} !== exp_tab[i]) begin
        errors++;
        $display("FAIL oneshot_cyc%0d: got {Q,TC,BUSY}=%b, expected %b", i, {bus.Q, bus.TC, bus.BUSY}, exp_tab[i]);
      end
    end
    bus.CE = 1'b0;
  endtask

  task automatic test_wrap();
    logic [5:0] exp;
    bus.L = 1'b1; bus.D = 4'd2; bus.MODE = 1'b1; bus.CE = 1'b0;
    tick();
    exp = {4'd2, 1'b0, 1'b1};
    checks++;
    if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
      errors++;
      $display("FAIL wrap_load: got {Q,TC,BUSY}=%b, expected %b", {bus.Q, bus.TC, bus.BUSY}, exp);
    end
    bus.L = 1'b0; bus.CE = 1'b1;
    // Q after k enabled edges is (2-k) mod 16; TC only where 1 -> 0 (k=2, 18).
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = {4'(2 - k), (k == 2 || k == 18), 1'b1};
      checks++;
      if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
        errors++;
        $display("FAIL wrap_k%0d: got {Q,TC,BUSY}=%b, expected %b", k, {bus.Q, bus.TC, bus.BUSY}, exp);
      end
    end
    bus.CE = 1'b0;
  endtask

  task automatic test_enable_gaps();
    logic       ce_tab [5];
    logic [3:0] q_tab  [5];
    logic [5:0] exp;
    ce_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    q_tab  = '{4'd4, 4'd4, 4'd4, 4'd3, 4'd2};
    bus.L = 1'b1; bus.D = 4'd5; bus.MODE = 1'b0; bus.CE = 1'b0;
    tick();
    bus.L = 1'b0;
    exp = {4'd5, 1'b0, 1'b1};
    checks++;
    if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
      errors++;
      $display("FAIL gaps_load: got {Q,TC,BUSY}=%b, expected %b", {bus.Q, bus.TC, bus.BUSY}, exp);
    end
    for (int i = 0; i < 5; i++) begin
      bus.CE = ce_tab[i];
      tick();
      exp = {q_tab[i], 1'b0, 1'b1};
      checks++;
      if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
        errors++;
        $display("FAIL gaps_cyc%0d: got {Q,TC,BUSY}=%b, expected %b", i, {bus.Q, bus.TC, bus.BUSY}, exp);
      end
    end
    bus.CE = 1'b0;
  endtask

  task automatic test_load_edges();
    logic [5:0] exp;
    // Zero load in one-shot goes straight to DONE.
    bus.L = 1'b1; bus.D = 4'd0; bus.MODE = 1'b0; bus.CE = 1'b1;
    tick();
    bus.L = 1'b0;
    exp = {4'd0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
        errors++;
        $display("FAIL zero_load_cyc%0d: got {Q,TC,BUSY}=%b, expected %b", i, {bus.Q, bus.TC, bus.BUSY}, exp);
      end
      tick();
    end
    // Load wins over CE while counting.
    bus.L = 1'b1; bus.D = 4'd10; bus.MODE = 1'b1;
    tick();
    bus.L = 1'b0;
    tick();
    bus.L = 1'b1; bus.D = 4'd7;
    tick();
    bus.L = 1'b0; bus.CE = 1'b0;
    exp = {4'd7, 1'b0, 1'b1};
    checks++;
    if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
      errors++;
      $display("FAIL load_beats_ce: got {Q,TC,BUSY}=%b, expected %b", {bus.Q, bus.TC, bus.BUSY}, exp);
    end
    // Load during the TC cycle drops TC.
    bus.L = 1'b1; bus.D = 4'd1; bus.MODE = 1'b0;
    tick();
    bus.L = 1'b0; bus.CE = 1'b1;
    tick();
    exp = {4'd0, 1'b1, 1'b0};
    checks++;
    if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
      errors++;
      $display("FAIL tc_before_load: got {Q,TC,BUSY}=%b, expected %b", {bus.Q, bus.TC, bus.BUSY}, exp);
    end
    bus.L = 1'b1; bus.D = 4'd4; bus.CE = 1'b0;
    tick();
    bus.L = 1'b0;
    exp = {4'd4, 1'b0, 1'b1};
    checks++;
    if ({bus.Q, bus.TC, bus.BUSY} !== exp) begin
      errors++;
      $display("FAIL load_in_tc_cycle: got {Q,TC,BUSY}=%b, expected %b", {bus.Q, bus.TC, bus.BUSY}, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_oneshot();
    test_wrap();
    test_enable_gaps();
    test_load_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
